// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner and its consumers.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // Column drive after reset or abort: column 0 low, the others released.
    localparam logic [3:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Key codes are {row_idx, col_idx} for the usual telephone-style 4x4 layout.
    localparam logic [3:0] KEY_1    = 4'h0;
    localparam logic [3:0] KEY_2    = 4'h1;
    localparam logic [3:0] KEY_3    = 4'h2;
    localparam logic [3:0] KEY_A    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_B    = 4'h7;
    localparam logic [3:0] KEY_7    = 4'h8;
    localparam logic [3:0] KEY_8    = 4'h9;
    localparam logic [3:0] KEY_9    = 4'hA;
    localparam logic [3:0] KEY_C    = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_0    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    // True when exactly one active-low row line is pulled down.
    function automatic logic one_low(input logic [3:0] pat);
        return ($countones(~pat) == 1);
    endfunction

    // Index of the low row; only meaningful when one_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < ROWS; i++) begin
            if (!pat[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: enable and raw rows in, column drive and key events out.
interface keypad_scanner_if;
    logic       scan_enable;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic [3:0] keypad_data;
    logic       keypad_enable;
    logic       key_held;

    // The scanner itself.
    modport master (
        input  scan_enable,
        input  keypad_row,
        output keypad_col,
        output keypad_data,
        output keypad_enable,
        output key_held
    );

    // The environment: keypad matrix plus the key-code consumer.
    modport slave (
        output scan_enable,
        output keypad_row,
        input  keypad_col,
        input  keypad_data,
        input  keypad_enable,
        input  key_held
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, reset to all-ones.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: reset to ones, not zeros -- ones is the idle (no key) level of the pulled-up rows.
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, debounce, one strobe per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  bus
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] S_SCAN     = SCAN;
    localparam logic [1:0] S_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] S_PRESSED  = PRESSED;
    localparam logic [1:0] S_RELEASE  = RELEASE;

    logic [1:0]        state;
    logic [1:0]        col_idx;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [1:0]        cand_row;
    logic [3:0]        cand_pat;
    logic [3:0]        rs;
    logic [3:0]        data_q;
    logic              enable_q;
    logic              held_q;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.keypad_row),
        .q     (rs)
    );

    // The candidate column is never changed while a key is being tracked,
    // so col_idx doubles as the latched column of the candidate key.
    assign cand_pat          = ~(4'b0001 << cand_row);
    assign bus.keypad_col    = ~(4'b0001 << col_idx);
    assign bus.keypad_data   = data_q;
    assign bus.keypad_enable = enable_q;
    assign bus.key_held      = held_q;

    // Scan / debounce / hold / release sequencing and key-event outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_SCAN;
            col_idx  <= 2'd0;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            cand_row <= 2'd0;
            data_q   <= 4'h0;
            enable_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            // NOTE: default low every cycle; only the accept branch raises it, so it is a one-cycle pulse.
            enable_q <= 1'b0;
            if (!bus.scan_enable) begin
                state    <= S_SCAN;
                col_idx  <= 2'd0;
                scan_cnt <= '0;
                deb_cnt  <= '0;
                held_q   <= 1'b0;
            end else begin
                case (state)
                    S_SCAN: begin
                        if (scan_cnt == SCAN_LAST) begin
                            scan_cnt <= '0;
                            if (one_low(rs)) begin
                                cand_row <= low_index(rs);
                                deb_cnt  <= '0;
                                state    <= S_DEBOUNCE;
                            end else begin
                                col_idx <= col_idx + 2'd1;
                            end
                        end else begin
                            scan_cnt <= scan_cnt + 1'b1;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (rs == cand_pat) begin
                            if (deb_cnt == DEB_LAST) begin
                                data_q   <= {cand_row, col_idx};
                                enable_q <= 1'b1;
                                held_q   <= 1'b1;
                                state    <= S_PRESSED;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            state   <= S_SCAN;
                        end
                    end
                    S_PRESSED: begin
                        // Other keys are ignored here; only a fully released row set moves on.
                        if (rs == 4'hF) begin
                            deb_cnt <= '0;
                            state   <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (rs != 4'hF) begin
                            state <= S_PRESSED;
                        end else if (deb_cnt == DEB_LAST) begin
                            held_q  <= 1'b0;
                            col_idx <= col_idx + 2'd1;
                            state   <= S_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
`timescale 1ns/1ps
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    // Worst-case press-to-strobe latency: 2 sync + 4 columns + debounce + 1.
    localparam int MAX_LAT      = 2 + 4 * SCAN_DIV + DEBOUNCE_CNT + 1;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] pressed;     // bit r*4+c set while key (row r, col c) is down
    logic [3:0]  row_model;

    keypad_scanner_if bus ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Matrix model: a row is pulled low when a pressed key sits on a driven-low column.
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !bus.keypad_col[c]) row_model[r] = 1'b0;
    end
    assign bus.keypad_row = row_model;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor, sampled just after each rising edge.
    int   strobes = 0;
    logic prev_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset && bus.keypad_enable) begin
            strobes++;
            check("no_back_to_back_strobe", 32'(prev_en), 32'd0);
        end
        prev_en = bus.keypad_enable;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input int max_cyc, output logic found, output int cyc, output logic [3:0] code);
        found = 1'b0;
        cyc   = 0;
        code  = 4'h0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.keypad_enable) begin
                found = 1'b1;
                cyc   = i;
                code  = bus.keypad_data;
                break;
            end
        end
    endtask

    task automatic wait_col(input logic [3:0] want, input int max_cyc, output logic found, output int cyc);
        found = 1'b0;
        cyc   = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.keypad_col == want) begin
                found = 1'b1;
                cyc   = i;
                break;
            end
        end
    endtask

    task automatic wait_released(input int max_cyc, output logic found);
        found = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (!bus.key_held) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic       scan_en;
        logic [3:0] exp_col;
    } vec_t;

    vec_t vecs [27];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       found;
        int         cyc;
        int         s0;
        logic [3:0] code;

        reset           = 1'b0;
        bus.scan_enable = 1'b1;
        pressed         = 16'h0;
        tick(3);
        check("reset_col",    32'(bus.keypad_col),    32'(COL_IDLE));
        check("reset_data",   32'(bus.keypad_data),   32'h0);
        check("reset_enable", 32'(bus.keypad_enable), 32'h0);
        check("reset_held",   32'(bus.key_held),      32'h0);
        reset = 1'b1;

        // Idle scan: 4 clocks per column; scan_enable dropped mid column 1 snaps back to column 0.
        vecs[0]  = '{1'b1, 4'b1110}; vecs[1]  = '{1'b1, 4'b1110}; vecs[2]  = '{1'b1, 4'b1110};
        vecs[3]  = '{1'b1, 4'b1101}; vecs[4]  = '{1'b1, 4'b1101}; vecs[5]  = '{1'b1, 4'b1101};
        vecs[6]  = '{1'b1, 4'b1101}; vecs[7]  = '{1'b1, 4'b1011}; vecs[8]  = '{1'b1, 4'b1011};
        vecs[9]  = '{1'b1, 4'b1011}; vecs[10] = '{1'b1, 4'b1011}; vecs[11] = '{1'b1, 4'b0111};
        vecs[12] = '{1'b1, 4'b0111}; vecs[13] = '{1'b1, 4'b0111}; vecs[14] = '{1'b1, 4'b0111};
        vecs[15] = '{1'b1, 4'b1110}; vecs[16] = '{1'b1, 4'b1110}; vecs[17] = '{1'b1, 4'b1110};
        vecs[18] = '{1'b1, 4'b1110}; vecs[19] = '{1'b1, 4'b1101}; vecs[20] = '{1'b0, 4'b1110};
        vecs[21] = '{1'b0, 4'b1110}; vecs[22] = '{1'b1, 4'b1110}; vecs[23] = '{1'b1, 4'b1110};
        vecs[24] = '{1'b1, 4'b1110}; vecs[25] = '{1'b1, 4'b1101}; vecs[26] = '{1'b1, 4'b1101};

        for (int i = 0; i < 27; i++) begin
            bus.scan_enable = vecs[i].scan_en;
            @(negedge clk);
            check($sformatf("idle_col[%0d]", i),    32'(bus.keypad_col),    32'(vecs[i].exp_col));
            check($sformatf("idle_enable[%0d]", i), 32'(bus.keypad_enable), 32'h0);
            check($sformatf("idle_data[%0d]", i),   32'(bus.keypad_data),   32'h0);
        end
        check("idle_strobe_count", 32'(strobes), 32'd0);

        // Clean press of row 2 / col 1 for 40 clocks.
        s0 = strobes;
        pressed[9] = 1'b1;
        wait_strobe(MAX_LAT, found, cyc, code);
        check("press_found", 32'(found), 32'd1);
        check("press_code",  32'(code),  32'h9);
        check("press_held",  32'(bus.key_held), 32'd1);
        tick(40 - cyc);
        check("press_single_strobe", 32'(strobes - s0), 32'd1);
        pressed = 16'h0;
        // Released rows reach the FSM after 2 sync clocks, 1 clock to leave PRESSED, then 8 debounce clocks.
        tick(10);
        check("release_held_before", 32'(bus.key_held), 32'd1);
        tick(1);
        check("release_held_after",  32'(bus.key_held), 32'd0);
        check("release_data_kept",   32'(bus.keypad_data), 32'h9);

        // Bounce on row 1 / col 2: 10 phases of 3 clocks, ending released, then stable.
        tick(5);
        s0 = strobes;
        for (int p = 0; p < 10; p++) begin
            pressed[6] = (p % 2 == 0);
            tick(3);
        end
        check("bounce_no_strobe", 32'(strobes - s0), 32'd0);
        pressed[6] = 1'b1;
        wait_strobe(MAX_LAT, found, cyc, code);
        check("bounce_found",       32'(found), 32'd1);
        check("bounce_code",        32'(code),  32'h6);
        check("bounce_min_latency", 32'(cyc >= 11), 32'd1);
        tick(10);
        check("bounce_single_strobe", 32'(strobes - s0), 32'd1);
        pressed = 16'h0;
        wait_released(20, found);
        check("bounce_release", 32'(found), 32'd1);

        // Two rows low on column 0: rejected, scanning moves on after the normal 4 clocks.
        tick(3);
        s0 = strobes;
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        wait_col(4'b0111, 20, found, cyc);
        check("multi_reach_col3", 32'(found), 32'd1);
        wait_col(4'b1110, 8, found, cyc);
        check("multi_reach_col0", 32'(found), 32'd1);
        wait_col(4'b1101, 10, found, cyc);
        check("multi_advance_col1", 32'(found), 32'd1);
        check("multi_advance_time", 32'(cyc), 32'd4);
        tick(40);
        check("multi_no_strobe", 32'(strobes - s0), 32'd0);
        pressed = 16'h0;
        tick(5);

        // Second key while first is held; both released before scanning resumes.
        s0 = strobes;
        pressed[9] = 1'b1;
        wait_strobe(MAX_LAT, found, cyc, code);
        check("hold_found", 32'(found), 32'd1);
        check("hold_code",  32'(code),  32'h9);
        tick(5);
        pressed[3] = 1'b1;
        tick(10);
        check("hold_second_ignored", 32'(strobes - s0), 32'd1);
        check("hold_still_held",     32'(bus.key_held), 32'd1);
        pressed[9] = 1'b0;
        tick(3);
        pressed[3] = 1'b0;
        tick(80);
        check("hold_only_first", 32'(strobes - s0), 32'd1);
        pressed[3] = 1'b1;
        wait_strobe(MAX_LAT, found, cyc, code);
        check("fresh_found", 32'(found), 32'd1);
        check("fresh_code",  32'(code),  32'(KEY_A));
        pressed = 16'h0;
        wait_released(20, found);
        check("fresh_release", 32'(found), 32'd1);

        // Abort during DEBOUNCE, then resume with the key still held.
        tick(3);
        s0 = strobes;
        pressed[9] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.state == DEBOUNCE) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reach_debounce", 32'(found), 32'd1);
        bus.scan_enable = 1'b0;
        tick(1);
        check("abort_state",  32'(dut.state),         32'(SCAN));
        check("abort_col",    32'(bus.keypad_col),    32'(COL_IDLE));
        check("abort_enable", 32'(bus.keypad_enable), 32'd0);
        check("abort_data",   32'(bus.keypad_data),   32'(KEY_A));
        tick(9);
        check("abort_no_strobe", 32'(strobes - s0), 32'd0);
        check("abort_col_idle",  32'(bus.keypad_col), 32'(COL_IDLE));
        bus.scan_enable = 1'b1;
        wait_strobe(MAX_LAT, found, cyc, code);
        check("resume_found", 32'(found), 32'd1);
        check("resume_code",  32'(code),  32'h9);

        // Abort while PRESSED clears key_held but keeps the code.
        tick(3);
        bus.scan_enable = 1'b0;
        tick(1);
        check("abort_pressed_held", 32'(bus.key_held),    32'd0);
        check("abort_pressed_data", 32'(bus.keypad_data), 32'h9);
        check("abort_pressed_col",  32'(bus.keypad_col),  32'(COL_IDLE));
        pressed = 16'h0;
        tick(3);
        bus.scan_enable = 1'b1;
        tick(20);
        check("total_strobes", 32'(strobes), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
